// File: rtl/fsm_table_engine_if.sv
// Bus bundle for the table-driven FSM engine: condition inputs, table write port,
// run/step/load controls and the engine's observable state.
interface fsm_table_engine_if #(
    parameter int STATE_BITS = 4,
    parameter int INPUT_BITS = 8,
    parameter int OUT_BITS   = 4
);
    localparam int SEL_BITS = $clog2(INPUT_BITS);
    localparam int ENTRY_W  = OUT_BITS + 2*STATE_BITS + SEL_BITS + 2;

    logic [INPUT_BITS-1:0] fsm_input;
    logic                  cfg_we;
    logic [STATE_BITS-1:0] cfg_addr;
    logic [ENTRY_W-1:0]    cfg_wdata;
    logic                  ctrl_run;
    logic                  ctrl_step;
    logic                  ctrl_load;
    logic [STATE_BITS-1:0] ctrl_start_state;
    logic [STATE_BITS-1:0] fsm_state;
    logic [OUT_BITS-1:0]   fsm_out;
    logic                  fsm_halted;
    logic                  fsm_changed;
    logic [15:0]           trans_count;

    modport master (
        output fsm_input, cfg_we, cfg_addr, cfg_wdata,
        output ctrl_run, ctrl_step, ctrl_load, ctrl_start_state,
        input  fsm_state, fsm_out, fsm_halted, fsm_changed, trans_count
    );

    modport slave (
        input  fsm_input, cfg_we, cfg_addr, cfg_wdata,
        input  ctrl_run, ctrl_step, ctrl_load, ctrl_start_state,
        output fsm_state, fsm_out, fsm_halted, fsm_changed, trans_count
    );
endinterface

// File: rtl/fsm_table_engine.sv
// CPU-programmable FSM: one transition entry per state selects an input bit,
// optionally inverts it, and picks next_true/next_false; halt states park the engine.
module fsm_table_engine #(
    parameter int STATE_BITS = 4,
    parameter int INPUT_BITS = 8,
    parameter int OUT_BITS   = 4
) (
    input logic clk,
    input logic rst_n,
    fsm_table_engine_if.slave bus
);
    localparam int NUM_STATES = 1 << STATE_BITS;
    localparam int SEL_BITS   = $clog2(INPUT_BITS);
    localparam int ENTRY_W    = OUT_BITS + 2*STATE_BITS + SEL_BITS + 2;
    localparam int NF_LSB     = OUT_BITS;
    localparam int NT_LSB     = OUT_BITS + STATE_BITS;
    localparam int SEL_LSB    = OUT_BITS + 2*STATE_BITS;
    localparam int INV_BIT    = SEL_LSB + SEL_BITS;
    localparam int HALT_BIT   = INV_BIT + 1;

    typedef enum logic [0:0] {
        MODE_ACTIVE = 1'b0,
        MODE_HALTED = 1'b1
    } mode_e;

    logic [ENTRY_W-1:0]    tbl [NUM_STATES];
    logic [STATE_BITS-1:0] state_q, state_d;
    mode_e                 mode_q, mode_d;
    logic                  changed_q, changed_d;
    logic [15:0]           count_q, count_d;

    logic [ENTRY_W-1:0]    cur_entry;
    logic [SEL_BITS-1:0]   cur_sel;
    logic                  cond;
    logic                  adv;
    logic [STATE_BITS-1:0] target;
    logic                  target_halt;

    // Lookups read the table as it stood before this edge's cfg write.
    always_comb begin
        cur_entry   = tbl[state_q];
        cur_sel     = cur_entry[SEL_LSB +: SEL_BITS];
        cond        = bus.fsm_input[cur_sel] ^ cur_entry[INV_BIT];
        adv         = (bus.ctrl_run | bus.ctrl_step) & (mode_q == MODE_ACTIVE) & ~bus.ctrl_load;
        target      = bus.ctrl_load ? bus.ctrl_start_state
                    : (cond ? cur_entry[NT_LSB +: STATE_BITS] : cur_entry[NF_LSB +: STATE_BITS]);
        target_halt = tbl[target][HALT_BIT];
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        count_d = count_q;
        if (bus.ctrl_load) begin
            state_d = target;
            mode_d  = target_halt ? MODE_HALTED : MODE_ACTIVE;
            count_d = 16'd0;
        end else if (adv) begin
            state_d = target;
            mode_d  = target_halt ? MODE_HALTED : MODE_ACTIVE;
            count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
        end
        changed_d = (state_d != state_q);
    end

    // Reset clears the program too; a restarted engine never inherits an old table.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= '0;
            mode_q    <= MODE_ACTIVE;
            changed_q <= 1'b0;
            count_q   <= 16'd0;
            for (int i = 0; i < NUM_STATES; i++) begin
                tbl[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            changed_q <= changed_d;
            count_q   <= count_d;
            if (bus.cfg_we) begin
                tbl[bus.cfg_addr] <= bus.cfg_wdata;
            end
        end
    end

    assign bus.fsm_state   = state_q;
    assign bus.fsm_out     = tbl[state_q][OUT_BITS-1:0];
    assign bus.fsm_halted  = (mode_q == MODE_HALTED);
    assign bus.fsm_changed = changed_q;
    assign bus.trans_count = count_q;
endmodule
